// File: rtl/risc_datapath.sv
// Execution datapath of the 3-bit-opcode accumulator CPU: PC, IR, accumulator,
// operand latch and ALU, sequenced by the controller strobes and a lock-step phase counter.
module risc_datapath #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  mem_rd,
    input  logic                  load_ir,
    input  logic                  halt,
    input  logic                  inc_pc,
    input  logic                  load_ac,
    input  logic                  load_pc,
    input  logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            opcode,
    output logic                  zero,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] acc_o,
    output logic                  halted,
    output logic                  seq_err
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpAnd = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpLda = 3'b011;
    localparam logic [2:0] OpJmp = 3'b101;

    localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    if (DATA_WIDTH != ADDR_WIDTH + 3) begin : g_width_check
        $fatal(1, "risc_datapath: DATA_WIDTH must equal ADDR_WIDTH+3");
    end

    logic [2:0]            r_phase;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_opnd;
    logic                  r_halted;
    logic                  r_seq_err;

    logic                  w_frozen;
    logic                  w_seq_bad;
    logic [ADDR_WIDTH-1:0] w_ir_addr;
    logic [DATA_WIDTH-1:0] w_alu;

    // The halt edge itself is frozen as well, so halt beats any simultaneous update.
    assign w_frozen  = r_halted | halt;
    assign w_ir_addr = r_ir[ADDR_WIDTH-1:0];

    assign w_seq_bad = (load_ir && r_phase != 3'd2) ||
                       (mem_wr  && r_phase != 3'd7) ||
                       (load_pc && r_phase != 3'd6) ||
                       (halt    && r_phase != 3'd4);

    always_comb begin
        w_alu = r_acc;
        case (opcode)
            OpAdd:   w_alu = r_acc + r_opnd;
            OpAnd:   w_alu = r_acc & r_opnd;
            OpXor:   w_alu = r_acc ^ r_opnd;
            OpLda:   w_alu = r_opnd;
            default: w_alu = r_acc;
        endcase
    end

    // Free-running so it stays in lock with the controller, even while halted.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (!w_frozen) begin
            if (load_ir) begin
                r_ir <= mem_rdata;
            end
            if (load_ac && r_phase == 3'd5) begin
                r_opnd <= mem_rdata;
            end
            // load_ac spans phases 5 and 6; only phase 6 commits the ALU result.
            if (load_ac && r_phase == 3'd6) begin
                r_acc <= w_alu;
            end
            if (load_pc && opcode == OpJmp) begin
                r_pc <= w_ir_addr;
            end else if (inc_pc) begin
                r_pc <= r_pc + PcOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_halted  <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign opcode    = r_ir[DATA_WIDTH-1:ADDR_WIDTH];
    assign zero      = (r_acc == '0);
    assign mem_addr  = (r_phase < 3'd3) ? r_pc : w_ir_addr;
    assign mem_wdata = r_acc;
    assign mem_re    = mem_rd & ~r_halted;
    assign mem_we    = mem_wr & ~r_halted;
    assign pc_o      = r_pc;
    assign acc_o     = r_acc;
    assign halted    = r_halted;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: bench-side controller, memory and a
// cycle model of the architectural state, checked every cycle plus literal expectations.
module tb_risc_datapath;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpAnd = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpLda = 3'b011;
    localparam logic [2:0] OpSkz = 3'b100;
    localparam logic [2:0] OpJmp = 3'b101;
    localparam logic [2:0] OpSto = 3'b110;
    localparam logic [2:0] OpHlt = 3'b111;

    logic          clk = 1'b0;
    logic          rst_;
    logic          mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    opcode;
    logic          zero;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] acc_o;
    logic          halted, seq_err;

    logic [DW-1:0] tb_mem [32];
    logic [DW-1:0] m_mem  [32];

    int            m_phase;
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir, m_acc, m_opnd;
    logic          m_halted, m_err;

    logic f_load_ir = 1'b0;
    logic f_inc_pc  = 1'b0;
    logic chk_en    = 1'b0;

    int            n_checks = 0;
    int            n_errs   = 0;
    int            we_count;
    int            we_phase;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;
    int            io_count;

    always #5 clk = ~clk;

    assign mem_rdata = mem_re ? tb_mem[mem_addr] : '0;

    risc_datapath #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_(rst_),
        .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
        .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .opcode(opcode), .zero(zero), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .pc_o(pc_o), .acc_o(acc_o),
        .halted(halted), .seq_err(seq_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] m_addr();
        return (m_phase < 3) ? m_pc : m_ir[AW-1:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_o",      32'(pc_o),      32'(m_pc));
            check("acc_o",     32'(acc_o),     32'(m_acc));
            check("opcode",    32'(opcode),    32'(m_ir[7:5]));
            check("zero",      32'(zero),      32'(m_acc == '0));
            check("mem_addr",  32'(mem_addr),  32'(m_addr()));
            check("mem_wdata", 32'(mem_wdata), 32'(m_acc));
            check("mem_re",    32'(mem_re),    32'(mem_rd && !m_halted));
            check("mem_we",    32'(mem_we),    32'(mem_wr && !m_halted));
            check("halted",    32'(halted),    32'(m_halted));
            check("seq_err",   32'(seq_err),   32'(m_err));
        end
    end

    // One clock of the architectural rules, applied to the strobes held over the edge.
    task automatic model_step();
        logic [AW-1:0] a;
        logic [DW-1:0] rd, res;
        logic [2:0]    op;
        a  = m_addr();
        rd = (mem_rd && !m_halted) ? m_mem[a] : '0;
        op = m_ir[7:5];
        if ((load_ir && m_phase != 2) || (mem_wr && m_phase != 7) ||
            (load_pc && m_phase != 6) || (halt && m_phase != 4)) m_err = 1'b1;
        if (mem_wr && !m_halted) m_mem[a] = m_acc;
        case (op)
            OpAdd:   res = m_acc + m_opnd;
            OpAnd:   res = m_acc & m_opnd;
            OpXor:   res = m_acc ^ m_opnd;
            OpLda:   res = m_opnd;
            default: res = m_acc;
        endcase
        if (!m_halted && !halt) begin
            if (load_ac && m_phase == 6) m_acc = res;
            if (load_ac && m_phase == 5) m_opnd = rd;
            if (load_pc && op == OpJmp) m_pc = m_ir[AW-1:0];
            else if (inc_pc) m_pc = m_pc + 5'd1;
            if (load_ir) m_ir = rd;
        end
        if (halt) m_halted = 1'b1;
        m_phase = (m_phase + 1) % 8;
    endtask

    // Bench controller: strobes per phase from the model's opcode and zero flag.
    task automatic cycle();
        logic [2:0] op;
        logic       alu, z, sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        op = m_ir[7:5];
        alu = (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
        z  = (m_acc == '0);
        mem_rd  = (m_phase == 1) || (m_phase == 2) || ((m_phase == 5 || m_phase == 6) && alu);
        load_ir = (m_phase == 2) || f_load_ir;
        inc_pc  = (m_phase == 3) || (m_phase == 6 && op == OpSkz && z) || f_inc_pc;
        halt    = (m_phase == 4) && (op == OpHlt);
        load_ac = (m_phase == 5 || m_phase == 6) && alu;
        load_pc = (m_phase == 6) && (op == OpJmp || op == OpSkz);
        mem_wr  = (m_phase == 7) && (op == OpSto);
        @(negedge clk);
        sw = mem_we;
        sa = mem_addr;
        sd = mem_wdata;
        if (mem_re || mem_we) io_count++;
        if (sw) begin
            we_count++;
            we_phase = m_phase;
            we_addr  = sa;
            we_data  = sd;
        end
        @(posedge clk);
        model_step();
        if (sw) tb_mem[sa] = sd;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_assert();
        rst_ = 1'b0;
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '0;
        f_load_ir = 1'b0;
        f_inc_pc  = 1'b0;
        m_phase = 0; m_pc = '0; m_ir = '0; m_acc = '0; m_opnd = '0;
        m_halted = 1'b0; m_err = 1'b0;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] = '0;
            m_mem[i]  = '0;
        end
    endtask

    task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_mem[a] = d;
        m_mem[a]  = d;
    endtask

    initial begin
        clear_mem();
        reset_assert();
        chk_en = 1'b1;
        reset_release();

        // Reset in the middle of phase 5 with acc=0x3C.
        set_mem(5'h00, 8'h74);
        set_mem(5'h14, 8'h3C);
        run(13);
        check("acc_before_reset", 32'(acc_o), 32'h3C);
        reset_assert();
        #1;
        check("acc_async_reset", 32'(acc_o), 32'h00);
        reset_release();
        check("pc_after_reset",   32'(pc_o),     32'h00);
        check("addr_after_reset", 32'(mem_addr), 32'h00);
        check("zero_after_reset", 32'(zero),     32'h1);
        check("op_after_reset",   32'(opcode),   32'h0);

        // LDA / ADD with carry out / AND / XOR.
        clear_mem();
        set_mem(5'h00, 8'h74); set_mem(5'h01, 8'h15);
        set_mem(5'h02, 8'h36); set_mem(5'h03, 8'h57);
        set_mem(5'h14, 8'h07); set_mem(5'h15, 8'hFE);
        set_mem(5'h16, 8'h0C); set_mem(5'h17, 8'hFF);
        reset_assert(); reset_release();
        run(8);
        check("acc_lda", 32'(acc_o), 32'h07);
        run(8);
        check("acc_add", 32'(acc_o), 32'h05);
        check("pc_add",  32'(pc_o),  32'h02);
        run(8);
        check("acc_and", 32'(acc_o), 32'h04);
        run(8);
        check("acc_xor", 32'(acc_o), 32'hFB);

        // SKZ with acc=0 skips.
        clear_mem();
        set_mem(5'h00, 8'hA3); set_mem(5'h03, 8'h80);
        reset_assert(); reset_release();
        run(8);
        check("pc_jmp3", 32'(pc_o), 32'h03);
        run(8);
        check("pc_skz_taken", 32'(pc_o), 32'h05);

        // SKZ with acc=1 does not skip; JMP 0x1A; pc wrap 0x1F -> 0x00.
        clear_mem();
        set_mem(5'h00, 8'h7E); set_mem(5'h1E, 8'h01); set_mem(5'h01, 8'hA3);
        set_mem(5'h03, 8'h80); set_mem(5'h04, 8'hBA); set_mem(5'h1A, 8'hBF);
        set_mem(5'h1F, 8'h80);
        reset_assert(); reset_release();
        run(24);
        check("pc_skz_not_taken", 32'(pc_o), 32'h04);
        run(8);
        check("pc_jmp1a", 32'(pc_o), 32'h1A);
        run(8);
        check("pc_jmp1f", 32'(pc_o), 32'h1F);
        run(8);
        check("pc_wrap", 32'(pc_o), 32'h00);

        // STO 0x10 with acc=0xA5.
        clear_mem();
        set_mem(5'h00, 8'h71); set_mem(5'h11, 8'hA5); set_mem(5'h01, 8'hD0);
        reset_assert(); reset_release();
        run(8);
        we_count = 0;
        we_phase = -1;
        we_addr  = '0;
        we_data  = '0;
        run(8);
        check("sto_pulses", 32'(we_count), 32'd1);
        check("sto_phase",  32'(we_phase), 32'd7);
        check("sto_addr",   32'(we_addr),  32'h10);
        check("sto_data",   32'(we_data),  32'hA5);
        check("sto_mem",    32'(tb_mem[5'h10]), 32'hA5);

        // HLT at 6; inc_pc forced alongside halt must lose.
        clear_mem();
        set_mem(5'h00, 8'h74); set_mem(5'h14, 8'h3C);
        set_mem(5'h01, 8'hA6); set_mem(5'h06, 8'hE0);
        reset_assert(); reset_release();
        run(16);
        check("pc_at_hlt", 32'(pc_o), 32'h06);
        run(4);
        f_inc_pc = 1'b1;
        cycle();
        f_inc_pc = 1'b0;
        check("halted_set", 32'(halted), 32'h1);
        check("pc_halt",    32'(pc_o),   32'h07);
        io_count = 0;
        run(32);
        check("halt_io",      32'(io_count), 32'd0);
        check("pc_frozen",    32'(pc_o),     32'h07);
        check("acc_frozen",   32'(acc_o),    32'h3C);
        check("ir_frozen",    32'(opcode),   32'h7);
        check("halt_no_err",  32'(seq_err),  32'h0);

        // load_ir forced in phase 4.
        clear_mem();
        reset_assert(); reset_release();
        run(4);
        f_load_ir = 1'b1;
        cycle();
        f_load_ir = 1'b0;
        check("seq_err_set", 32'(seq_err), 32'h1);
        run(10);
        check("seq_err_sticky", 32'(seq_err), 32'h1);
        reset_assert();
        #1;
        check("seq_err_cleared", 32'(seq_err), 32'h0);
        reset_release();
        run(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
